// File: rtl/coherence_bus_ctrl_if.sv
// Cache/memory side bundle of the coherence bus controller.
interface coherence_bus_ctrl_if #(
  parameter int unsigned NCORES      = 2,
  parameter int unsigned BLOCK_WORDS = 2
);
  localparam int unsigned WIDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  // icache side
  logic [NCORES-1:0]    iREN;
  logic [32*NCORES-1:0] iaddr;
  logic [NCORES-1:0]    iwait;
  logic [31:0]          iload;

  // dcache side
  logic [NCORES-1:0]    dREN;
  logic [NCORES-1:0]    dWEN;
  logic [NCORES-1:0]    ccwrite;
  logic [32*NCORES-1:0] daddr;
  logic [32*NCORES-1:0] dstore;
  logic [NCORES-1:0]    dwait;
  logic [31:0]          dload;
  logic [WIDX_W-1:0]    word_idx;

  // snoop side
  logic [NCORES-1:0]    ccwait;
  logic [NCORES-1:0]    ccinv;
  logic [31:0]          ccsnoopaddr;
  logic [NCORES-1:0]    ccvalid;
  logic [NCORES-1:0]    cchit;

  // memory side
  logic                 ramREN;
  logic                 ramWEN;
  logic [31:0]          ramaddr;
  logic [31:0]          ramstore;
  logic [31:0]          ramload;
  logic                 ramready;

  // Controller view
  modport master (
    input  iREN, iaddr, dREN, dWEN, ccwrite, daddr, dstore, ccvalid, cchit,
           ramload, ramready,
    output iwait, iload, dwait, dload, word_idx, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  // Caches and memory view
  modport slave (
    output iREN, iaddr, dREN, dWEN, ccwrite, daddr, dstore, ccvalid, cchit,
           ramload, ramready,
    input  iwait, iload, dwait, dload, word_idx, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Multi-core coherence bus controller: arbitrates icache fills, dcache
// writebacks and snooping dcache block loads onto a single RAM port, with
// cache-to-cache transfer when a peer holds the block dirty.
module coherence_bus_ctrl #(
  parameter int unsigned NCORES      = 2,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input logic             CLK,
  input logic             RST,
  coherence_bus_ctrl_if.master bus
);

  localparam int unsigned WIDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int unsigned OWN_W  = $clog2(NCORES);
  localparam logic [31:0] BLK_MASK = ~32'(BLOCK_WORDS * 4 - 1);
  localparam logic [WIDX_W-1:0] LAST_K    = WIDX_W'(BLOCK_WORDS - 1);
  localparam logic [OWN_W-1:0]  LAST_CORE = OWN_W'(NCORES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IFETCH = 3'd1;
  localparam logic [2:0] S_DWB    = 3'd2;
  localparam logic [2:0] S_SNOOP  = 3'd3;
  localparam logic [2:0] S_DLD    = 3'd4;
  localparam logic [2:0] S_CCXFER = 3'd5;

  logic [2:0]        state, state_nx;
  logic [OWN_W-1:0]  owner, owner_nx;
  logic [OWN_W-1:0]  supplier, supplier_nx;
  logic [OWN_W-1:0]  iptr, iptr_nx;
  logic [OWN_W-1:0]  dptr, dptr_nx;
  logic [WIDX_W-1:0] k, k_nx;
  logic              inv, inv_nx;

  logic [NCORES-1:0] d_req, owner_oh, supplier_oh, others, hits;
  logic              d_any, i_any, snoop_done, last_word;
  logic [OWN_W-1:0]  d_gnt, i_gnt, h_gnt;
  logic [31:0]       own_iaddr, own_daddr, own_store, sup_store, base, waddr;

  // Index ptr+off wrapped into the core range
  function automatic logic [OWN_W-1:0] rr_idx(input logic [OWN_W-1:0] ptr,
                                              input int unsigned off);
    int unsigned s;
    s = (32'(ptr) + off) % NCORES;
    return OWN_W'(s);
  endfunction

  // Successor pointer with wrap NCORES-1 -> 0
  function automatic logic [OWN_W-1:0] inc(input logic [OWN_W-1:0] x);
    return (x == LAST_CORE) ? '0 : x + OWN_W'(1);
  endfunction

  // Round-robin grants, lowest-index snoop hit and per-core lane muxes
  always_comb begin
    d_req       = bus.dREN | bus.dWEN;
    d_any       = 1'b0;
    d_gnt       = '0;
    i_any       = 1'b0;
    i_gnt       = '0;
    h_gnt       = '0;
    own_iaddr   = '0;
    own_daddr   = '0;
    own_store   = '0;
    sup_store   = '0;
    owner_oh    = NCORES'(1) << owner;
    supplier_oh = NCORES'(1) << supplier;
    others      = ~owner_oh;
    hits        = bus.cchit & bus.ccvalid & others;
    snoop_done  = &(bus.ccvalid | owner_oh);
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (!d_any && d_req[rr_idx(dptr, i)]) begin
        d_any = 1'b1;
        d_gnt = rr_idx(dptr, i);
      end
      if (!i_any && bus.iREN[rr_idx(iptr, i)]) begin
        i_any = 1'b1;
        i_gnt = rr_idx(iptr, i);
      end
    end
    for (int unsigned i = NCORES; i > 0; i--) begin
      if (hits[OWN_W'(i - 1)]) h_gnt = OWN_W'(i - 1);
    end
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (owner == OWN_W'(i)) begin
        own_iaddr = bus.iaddr[32*i +: 32];
        own_daddr = bus.daddr[32*i +: 32];
        own_store = bus.dstore[32*i +: 32];
      end
      if (supplier == OWN_W'(i)) sup_store = bus.dstore[32*i +: 32];
    end
    base      = own_daddr & BLK_MASK;
    waddr     = base + (32'(k) << 2);
    last_word = (k == LAST_K);
  end

  // Next-state and bus outputs
  always_comb begin
    state_nx        = state;
    owner_nx        = owner;
    supplier_nx     = supplier;
    iptr_nx         = iptr;
    dptr_nx         = dptr;
    k_nx            = k;
    inv_nx          = inv;
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.word_idx    = k;
    case (state)
      S_IDLE: begin
        if (d_any) begin
          owner_nx = d_gnt;
          dptr_nx  = inc(d_gnt);
          k_nx     = '0;
          inv_nx   = bus.ccwrite[d_gnt];
          state_nx = bus.dWEN[d_gnt] ? S_DWB : S_SNOOP;
        end else if (i_any) begin
          owner_nx = i_gnt;
          iptr_nx  = inc(i_gnt);
          state_nx = S_IFETCH;
        end
      end
      S_IFETCH: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = own_iaddr;
        bus.iload   = bus.ramload;
        if (bus.ramready) begin
          bus.iwait = ~owner_oh;
          state_nx  = S_IDLE;
        end
      end
      S_DWB, S_DLD: begin
        bus.ramWEN  = (state == S_DWB);
        bus.ramREN  = (state == S_DLD);
        bus.ramaddr = waddr;
        if (state == S_DWB) bus.ramstore = own_store;
        else                bus.dload    = bus.ramload;
        if (bus.ramready) begin
          bus.dwait = ~owner_oh;
          k_nx      = last_word ? '0 : k + WIDX_W'(1);
          if (last_word) state_nx = S_IDLE;
        end
      end
      S_SNOOP: begin
        bus.ccsnoopaddr = base;
        bus.ccwait      = others;
        bus.ccinv       = inv ? others : '0;
        if (snoop_done) begin
          if (|hits) begin
            supplier_nx = h_gnt;
            state_nx    = S_CCXFER;
          end else begin
            state_nx    = S_DLD;
          end
        end
      end
      S_CCXFER: begin
        bus.ccsnoopaddr = base;
        bus.ccwait      = supplier_oh;
        bus.ccinv       = inv ? supplier_oh : '0;
        bus.ramWEN      = 1'b1;
        bus.ramaddr     = waddr;
        bus.ramstore    = sup_store;
        bus.dload       = sup_store;
        if (bus.ramready) begin
          bus.dwait = ~(owner_oh | supplier_oh);
          k_nx      = last_word ? '0 : k + WIDX_W'(1);
          if (last_word) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      owner    <= '0;
      supplier <= '0;
      iptr     <= '0;
      dptr     <= '0;
      k        <= '0;
      inv      <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      supplier <= supplier_nx;
      iptr     <= iptr_nx;
      dptr     <= dptr_nx;
      k        <= k_nx;
      inv      <= inv_nx;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: per-cycle vector table plus
// hand-written reset, cache-to-cache and 4-word writeback sequences.
module tb_coherence_bus_ctrl;

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] R  = 32'h1234_5678;
  localparam logic [31:0] D0 = 32'h0000_00D0;
  localparam logic [31:0] D1 = 32'h0000_00D1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  coherence_bus_ctrl_if #(.NCORES(2), .BLOCK_WORDS(2)) bus2 ();
  coherence_bus_ctrl_if #(.NCORES(2), .BLOCK_WORDS(4)) bus4 ();

  coherence_bus_ctrl #(.NCORES(2), .BLOCK_WORDS(2)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));
  coherence_bus_ctrl #(.NCORES(2), .BLOCK_WORDS(4)) dut4 (.CLK(CLK), .RST(RST), .bus(bus4));

  // The 4-word instance sees the same stimulus as the 2-word one
  assign bus4.iREN     = bus2.iREN;
  assign bus4.iaddr    = bus2.iaddr;
  assign bus4.dREN     = bus2.dREN;
  assign bus4.dWEN     = bus2.dWEN;
  assign bus4.ccwrite  = bus2.ccwrite;
  assign bus4.daddr    = bus2.daddr;
  assign bus4.dstore   = bus2.dstore;
  assign bus4.ccvalid  = bus2.ccvalid;
  assign bus4.cchit    = bus2.cchit;
  assign bus4.ramload  = bus2.ramload;
  assign bus4.ramready = bus2.ramready;

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  iren, dren, dwen, ccw, ccv, cch;
    logic        rr;
    logic        ren, wen;
    logic [31:0] addr, store, iload, dload;
    logic [1:0]  iwait, dwait, ccwait, ccinv;
    logic        widx;
  } vec_t;

  vec_t tbl [0:29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    bus2.iREN     = '0;
    bus2.dREN     = '0;
    bus2.dWEN     = '0;
    bus2.ccwrite  = '0;
    bus2.ccvalid  = '0;
    bus2.cchit    = '0;
    bus2.ramready = 1'b0;
    bus2.iaddr    = {32'h200, 32'h100};
    bus2.daddr    = {32'h3008, 32'h2004};
    bus2.dstore   = {D1, D0};
    bus2.ramload  = R;
    RST = 1'b1;
    adv();
    RST = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      bus2.iREN     = tbl[r].iren;
      bus2.dREN     = tbl[r].dren;
      bus2.dWEN     = tbl[r].dwen;
      bus2.ccwrite  = tbl[r].ccw;
      bus2.ccvalid  = tbl[r].ccv;
      bus2.cchit    = tbl[r].cch;
      bus2.ramready = tbl[r].rr;
      @(negedge CLK);
      chk($sformatf("row%0d ramREN", r),   32'(bus2.ramREN),   32'(tbl[r].ren));
      chk($sformatf("row%0d ramWEN", r),   32'(bus2.ramWEN),   32'(tbl[r].wen));
      chk($sformatf("row%0d ramaddr", r),  bus2.ramaddr,       tbl[r].addr);
      chk($sformatf("row%0d ramstore", r), bus2.ramstore,      tbl[r].store);
      chk($sformatf("row%0d iload", r),    bus2.iload,         tbl[r].iload);
      chk($sformatf("row%0d dload", r),    bus2.dload,         tbl[r].dload);
      chk($sformatf("row%0d iwait", r),    32'(bus2.iwait),    32'(tbl[r].iwait));
      chk($sformatf("row%0d dwait", r),    32'(bus2.dwait),    32'(tbl[r].dwait));
      chk($sformatf("row%0d ccwait", r),   32'(bus2.ccwait),   32'(tbl[r].ccwait));
      chk($sformatf("row%0d ccinv", r),    32'(bus2.ccinv),    32'(tbl[r].ccinv));
      chk($sformatf("row%0d word_idx", r), 32'(bus2.word_idx), 32'(tbl[r].widx));
      adv();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // iren  dren  dwen  ccw   ccv   cch   rr | ren wen addr      store iload dload iwait dwait ccwait ccinv widx
    // Two icache requests, round-robin, then iptr back at core 0
    tbl[0]  = '{2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[1]  = '{2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b1,1'b0,32'h100,  Z, R,Z, 2'b10,2'b11,2'b00,2'b00,1'b0};
    tbl[2]  = '{2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[3]  = '{2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b1,1'b0,32'h200,  Z, R,Z, 2'b01,2'b11,2'b00,2'b00,1'b0};
    tbl[4]  = '{2'b01,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[5]  = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 1'b1,1'b0,32'h100,  Z, R,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[6]  = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b1,1'b0,32'h100,  Z, R,Z, 2'b10,2'b11,2'b00,2'b00,1'b0};
    // Exclusive load by core 0, core 1 misses: one snoop cycle then RAM load
    tbl[7]  = '{2'b00,2'b01,2'b00,2'b01,2'b00,2'b00,1'b0, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[8]  = '{2'b00,2'b01,2'b00,2'b01,2'b10,2'b00,1'b0, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b10,2'b10,1'b0};
    tbl[9]  = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b1,1'b0,32'h2000, Z, Z,R, 2'b11,2'b10,2'b00,2'b00,1'b0};
    tbl[10] = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 1'b1,1'b0,32'h2004, Z, Z,R, 2'b11,2'b11,2'b00,2'b00,1'b1};
    tbl[11] = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b1,1'b0,32'h2004, Z, Z,R, 2'b11,2'b10,2'b00,2'b00,1'b1};
    // Writeback by core 1 (dptr now 1)
    tbl[12] = '{2'b00,2'b00,2'b10,2'b00,2'b00,2'b00,1'b0, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[13] = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b0,1'b1,32'h3008, D1,Z,Z, 2'b11,2'b01,2'b00,2'b00,1'b0};
    tbl[14] = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b0,1'b1,32'h300C, D1,Z,Z, 2'b11,2'b01,2'b00,2'b00,1'b1};
    // dREN and dWEN together from core 0: writeback wins
    tbl[15] = '{2'b00,2'b01,2'b01,2'b00,2'b00,2'b00,1'b0, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[16] = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b0,1'b1,32'h2000, D0,Z,Z, 2'b11,2'b10,2'b00,2'b00,1'b0};
    tbl[17] = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1, 1'b0,1'b1,32'h2004, D0,Z,Z, 2'b11,2'b10,2'b00,2'b00,1'b1};
    tbl[18] = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    // After reset: dcache0, dcache1, then icache0 (iwait[0] high throughout)
    tbl[19] = '{2'b01,2'b11,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[20] = '{2'b01,2'b11,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b10,2'b00,1'b0};
    tbl[21] = '{2'b01,2'b11,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b1,1'b0,32'h2000, Z, Z,R, 2'b11,2'b10,2'b00,2'b00,1'b0};
    tbl[22] = '{2'b01,2'b11,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b1,1'b0,32'h2004, Z, Z,R, 2'b11,2'b10,2'b00,2'b00,1'b1};
    tbl[23] = '{2'b01,2'b10,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[24] = '{2'b01,2'b10,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b01,2'b00,1'b0};
    tbl[25] = '{2'b01,2'b00,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b1,1'b0,32'h3008, Z, Z,R, 2'b11,2'b01,2'b00,2'b00,1'b0};
    tbl[26] = '{2'b01,2'b00,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b1,1'b0,32'h300C, Z, Z,R, 2'b11,2'b01,2'b00,2'b00,1'b1};
    tbl[27] = '{2'b01,2'b00,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};
    tbl[28] = '{2'b01,2'b00,2'b00,2'b00,2'b11,2'b00,1'b1, 1'b1,1'b0,32'h100,  Z, R,Z, 2'b10,2'b11,2'b00,2'b00,1'b0};
    tbl[29] = '{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0, 1'b0,1'b0,Z,        Z, Z,Z, 2'b11,2'b11,2'b00,2'b00,1'b0};

    // Reset state
    do_reset();
    @(negedge CLK);
    chk("rst iwait",   32'(bus2.iwait),  32'h3);
    chk("rst dwait",   32'(bus2.dwait),  32'h3);
    chk("rst ccwait",  32'(bus2.ccwait), 32'h0);
    chk("rst ramREN",  32'(bus2.ramREN), 32'h0);
    chk("rst ramWEN",  32'(bus2.ramWEN), 32'h0);
    chk("rst ramaddr", bus2.ramaddr,     32'h0);
    chk("rst4 dwait",  32'(bus4.dwait),  32'h3);
    adv();

    run_rows(0, 18);
    do_reset();
    run_rows(19, 29);

    // Reset in the middle of a block load
    do_reset();
    bus2.dREN = 2'b01;
    adv();
    bus2.dREN = 2'b00; bus2.ccvalid = 2'b10;
    @(negedge CLK);
    chk("rstA snoop ccwait", 32'(bus2.ccwait), 32'h2);
    chk("rstA snoop ccinv",  32'(bus2.ccinv),  32'h0);
    adv();
    bus2.ccvalid = 2'b00; bus2.ramready = 1'b1;
    @(negedge CLK);
    chk("rstA w0 ramaddr", bus2.ramaddr,     32'h2000);
    chk("rstA w0 dwait",   32'(bus2.dwait),  32'h2);
    adv();
    bus2.ramready = 1'b0; RST = 1'b1;
    @(negedge CLK);
    chk("rstA w1 word_idx", 32'(bus2.word_idx), 32'h1);
    chk("rstA w1 ramREN",   32'(bus2.ramREN),   32'h1);
    adv();
    RST = 1'b0; bus2.dREN = 2'b11;
    @(negedge CLK);
    chk("rstA post ramREN",   32'(bus2.ramREN),   32'h0);
    chk("rstA post dwait",    32'(bus2.dwait),    32'h3);
    chk("rstA post iwait",    32'(bus2.iwait),    32'h3);
    chk("rstA post word_idx", 32'(bus2.word_idx), 32'h0);
    chk("rstA post ramaddr",  bus2.ramaddr,       32'h0);
    adv();
    bus2.dREN = 2'b00;
    @(negedge CLK);
    chk("rstA dptr0 ccwait", 32'(bus2.ccwait), 32'h2);
    adv();

    // Delayed dirty hit in core 1: cache-to-cache transfer
    do_reset();
    bus2.dREN = 2'b01;
    adv();
    bus2.dREN = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("ccx wait%0d ccwait", c), 32'(bus2.ccwait), 32'h2);
      chk($sformatf("ccx wait%0d ccinv", c),  32'(bus2.ccinv),  32'h0);
      chk($sformatf("ccx wait%0d ram", c),    32'({bus2.ramREN, bus2.ramWEN}), 32'h0);
      chk($sformatf("ccx wait%0d snoopaddr", c), bus2.ccsnoopaddr, 32'h2000);
      adv();
    end
    bus2.ccvalid = 2'b10; bus2.cchit = 2'b10;
    @(negedge CLK);
    chk("ccx resp ccwait", 32'(bus2.ccwait), 32'h2);
    adv();
    bus2.ccvalid = 2'b00; bus2.cchit = 2'b00; bus2.ramready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      logic [31:0] sd;
      sd = (w == 0) ? 32'hBEEF : 32'hCAFE;
      bus2.dstore = {sd, D0};
      @(negedge CLK);
      chk($sformatf("ccx w%0d ramWEN", w),   32'(bus2.ramWEN),   32'h1);
      chk($sformatf("ccx w%0d ramREN", w),   32'(bus2.ramREN),   32'h0);
      chk($sformatf("ccx w%0d ramaddr", w),  bus2.ramaddr,       32'h2000 + 32'(4 * w));
      chk($sformatf("ccx w%0d ramstore", w), bus2.ramstore,      sd);
      chk($sformatf("ccx w%0d dload", w),    bus2.dload,         sd);
      chk($sformatf("ccx w%0d dwait", w),    32'(bus2.dwait),    32'h0);
      chk($sformatf("ccx w%0d ccwait", w),   32'(bus2.ccwait),   32'h2);
      chk($sformatf("ccx w%0d ccinv", w),    32'(bus2.ccinv),    32'h0);
      chk($sformatf("ccx w%0d word_idx", w), 32'(bus2.word_idx), 32'(w));
      adv();
    end
    bus2.ramready = 1'b0;
    @(negedge CLK);
    chk("ccx end ccwait", 32'(bus2.ccwait), 32'h0);
    chk("ccx end ramWEN", 32'(bus2.ramWEN), 32'h0);
    chk("ccx end dwait",  32'(bus2.dwait),  32'h3);
    adv();

    // Four-word writeback on the BLOCK_WORDS=4 instance
    do_reset();
    bus2.daddr = {32'h40C, 32'h2004};
    bus2.dWEN  = 2'b10;
    adv();
    bus2.dWEN = 2'b00; bus2.ramready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      bus2.dstore = {32'hA0 + 32'(w), D0};
      @(negedge CLK);
      chk($sformatf("wb4 w%0d ramWEN", w),   32'(bus4.ramWEN),   32'h1);
      chk($sformatf("wb4 w%0d ramREN", w),   32'(bus4.ramREN),   32'h0);
      chk($sformatf("wb4 w%0d ramaddr", w),  bus4.ramaddr,       32'h400 + 32'(4 * w));
      chk($sformatf("wb4 w%0d ramstore", w), bus4.ramstore,      32'hA0 + 32'(w));
      chk($sformatf("wb4 w%0d dwait", w),    32'(bus4.dwait),    32'h1);
      chk($sformatf("wb4 w%0d ccwait", w),   32'(bus4.ccwait),   32'h0);
      chk($sformatf("wb4 w%0d word_idx", w), 32'(bus4.word_idx), 32'(w));
      adv();
    end
    bus2.ramready = 1'b0;
    @(negedge CLK);
    chk("wb4 end ramWEN", 32'(bus4.ramWEN), 32'h0);
    chk("wb4 end dwait",  32'(bus4.dwait),  32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Parametrised successor to the two-cache bus controller.
- Arbitrates NCORES cores' icache fills, dcache writebacks and snooping dcache loads onto one RAM port.
- Supports BLOCK_WORDS-word blocks and cache-to-cache transfers with invalidation.
- Sits between the per-core caches and the memory interface.

Parameters:
NCORES, 2, number of cores (each core has one icache and one dcache), >=2
BLOCK_WORDS, 2, words per dcache block, power of two, >=1; WIDX_W = max(1, log2(BLOCK_WORDS))

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
iREN  in  NCORES  icache read request, per core
iaddr  in  32*NCORES  icache word address; core k uses [32k+31:32k]
iwait  out  NCORES  low for the cycle the core's icache word is delivered
iload  out  32  icache read data, broadcast
dREN  in  NCORES  dcache block-load request
dWEN  in  NCORES  dcache block-writeback request
ccwrite  in  NCORES  with dREN: load is for exclusive (write) ownership
daddr  in  32*NCORES  dcache block address
dstore  in  32*NCORES  dcache word being written back or supplied to a snoop
dwait  out  NCORES  low for the cycle one dcache word transfer completes
dload  out  32  dcache load data, broadcast
word_idx  out  WIDX_W  index of the current block word
ccwait  out  NCORES  snoop-in-progress; that core's dcache must service the snoop
ccinv  out  NCORES  invalidate the snooped block, valid with ccwait
ccsnoopaddr  out  32  block address being snooped
ccvalid  in  NCORES  snooped cache has a response ready
cchit  in  NCORES  snooped cache holds the block dirty; qualified by ccvalid
ramREN  out  1  memory read
ramWEN  out  1  memory write
ramaddr  out  32  memory word address
ramstore  out  32  memory write data
ramload  in  32  memory read data
ramready  in  1  memory access completes this cycle

Behaviour:
- Reset (RST high at a CLK edge, including mid-operation):
  - state=IDLE, all round-robin pointers=0, word counter=0.
  - All iwait/dwait=1; ccwait, ccinv, ramREN, ramWEN=0; addresses and data outputs=0.
- States: IDLE, IFETCH, DWB, SNOOP, DLD, CCXFER.
- IDLE arbitration, decided in one cycle, moves next cycle:
  - Any dREN|dWEN present: the dcache grant goes round-robin from dptr. The granted core is the owner, and dptr becomes owner+1 mod NCORES.
  - If the owner's dWEN is set, go to DWB. Otherwise go to SNOOP.
  - With no dcache request, iREN is granted round-robin from iptr: go to IFETCH and advance iptr.
  - dcache requests always beat icache requests.
- IFETCH:
  - ramREN=1, ramaddr=iaddr[owner], iload=ramload.
  - iwait[owner]=0 in the ramready cycle, then return to IDLE.
- Block addressing:
  - base = daddr[owner] with low log2(BLOCK_WORDS)+2 bits cleared.
  - Word k address = base + 4k, with word_idx=k.
- DWB:
  - ramWEN=1, ramstore=dstore[owner].
  - On each ramready: dwait[owner]=0 that cycle and k increments.
  - After word BLOCK_WORDS-1: k=0, go to IDLE.
- SNOOP:
  - ccsnoopaddr=base, ccwait[j]=1 for every j≠owner, and ccinv[j]=ccwrite[owner].
  - Stay in SNOOP until ccvalid is set for all j≠owner.
  - Then, if any valid cchit, the lowest-index hitting core becomes supplier and the state goes to CCXFER. Otherwise go to DLD.
- DLD:
  - ramREN=1, dload=ramload.
  - Word loop as in DWB (dwait low on each ramready, k increments); after the last word, go to IDLE.
- CCXFER:
  - ccwait[supplier] and ccinv[supplier] held.
  - ramWEN=1, ramstore=dstore[supplier], dload=dstore[supplier].
  - On ramready: dwait[owner]=0 and dwait[supplier]=0 that cycle.
  - The memory copy is updated while the requester is filled. After the last word, go to IDLE.
- ccwait and ccinv drop in the cycle the state leaves SNOOP/CCXFER.
- Request withdrawn mid-transaction: not permitted. The controller ignores request lines outside IDLE.
- Simultaneous dREN and dWEN from one core: dWEN wins.
- ramREN and ramWEN are never both high. Exactly one ram access is active in a non-IDLE, non-SNOOP state.
- Pointer wrap: NCORES-1 → 0.

Test Plan:
- Reset mid-DLD (NCORES=2, BLOCK_WORDS=2, assert RST after word 0) → next cycle state IDLE, ramREN=0, all dwait=1, word_idx=0, pointers 0.
- iREN[0], iREN[1] together, ramready every cycle, iaddr=0x100/0x200 → core0 served first (iwait[0] low, ramaddr 0x100), then core1 (ramaddr 0x200); iptr back to 0.
- dWEN[1] with daddr=0x40C, BLOCK_WORDS=4, dstore=0xA0..0xA3 → ramWEN writes 0x400,0x404,0x408,0x40C; dwait[1] low four times; no ccwait.
- dREN[0] with ccwrite=1, core1 ccvalid=1, cchit=0 → ccwait[1]=ccinv[1]=1 for one cycle, then DLD from RAM; dload=ramload per word.
- dREN[0] with ccwrite=0, core1 responds ccvalid=1, cchit=1 after 3 cycles, dstore[1]=0xBEEF,0xCAFE → CCXFER: ramWEN to base,base+4; dload matches; dwait[0] and dwait[1] low together; ccinv[1]=0.
- dREN[0], dREN[1], iREN[0] all asserted → dcache0, then dcache1, then icache0; iwait[0] stays high until both dcache transactions finish.
